// File: rtl/lift_pkg.sv
// Shared types and helpers for the lift shaft plant model.
//   shaft_state_t  : plant FSM states (IDLE, MOVE, CRASH)
//   sensor_t       : registered cabin position sensor bundle
//   DIR_UP/DIR_DOWN: direction encoding on the motor interface
//   decode_sensors : position -> sensor window decode
package lift_pkg;

  localparam int POS_W = 8;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    CRASH = 2'd2
  } shaft_state_t;

  typedef struct packed {
    logic top;
    logic middle_plus;
    logic middle_minus;
    logic bottom;
  } sensor_t;

  // Window decode done in signed int so that MID-SENSOR_W below zero
  // or POS_MAX-SENSOR_W below zero still compare sensibly.
  function automatic sensor_t decode_sensors(input logic [POS_W-1:0] pos,
                                             input int pos_max,
                                             input int sensor_w);
    sensor_t s;
    int      p;
    int      mid;
    p   = int'(pos);
    mid = pos_max / 2;
    s.bottom       = (p <= sensor_w);
    s.top          = (p >= pos_max - sensor_w);
    s.middle_minus = (p >= mid - sensor_w) && (p <= mid);
    s.middle_plus  = (p >= mid) && (p <= mid + sensor_w);
    return s;
  endfunction

endpackage

// File: rtl/lift_step_timer.sv
// Step-period prescaler for the lift shaft model.
//   clock : system clock
//   reset : synchronous, active-high
//   clear : restart the period at count 0 (wins over run)
//   run   : advance the count this cycle
//   tick  : one-cycle pulse in the last cycle of each period while running
// tick is purely a function of the count and run, never of clear, so the
// FSM may derive clear from a decision that itself looks at tick.
module lift_step_timer #(
  parameter int STEP_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every always_comb output gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state is written with <= only, so every register
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/lift_shaft_model.sv
// Plant model of the toy lift shaft: the far end of the controller's
// motor/sensor interface, so the board can close the loop without hardware.
//   clock, reset                : 50 MHz clock, synchronous active-high reset
//   enable, direction           : motor on, 1=up / 0=down
//   top, middle_plus,
//   middle_minus, bottom        : registered floor-window sensors (1-cycle lag)
//   position                    : cabin position 0..POS_MAX
//   moving                      : state MOVE
//   fault                       : latched overrun / illegal reversal
//   door_open                   : only with LIFT_DOOR_MODEL_EN defined
// Build option LIFT_DOOR_MODEL_EN adds the door model: the door opens after
// REV_STEPS step periods parked in a floor window, and enable while it is
// open crashes the plant.
module lift_shaft_model
  import lift_pkg::*;
#(
  parameter int POS_MAX   = 200,
  parameter int STEP_DIV  = 50000,
  parameter int SENSOR_W  = 4,
  parameter int REV_STEPS = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             direction,
  output logic             top,
  output logic             middle_plus,
  output logic             middle_minus,
  output logic             bottom,
  output logic [POS_W-1:0] position,
  output logic             moving,
`ifdef LIFT_DOOR_MODEL_EN
  output logic             door_open,
`endif
  output logic             fault
);

  if (POS_MAX > 255 || POS_MAX < 1) begin : g_pos_max_check
    $error("lift_shaft_model: POS_MAX must lie in 1..255");
  end

  localparam int STILL_W = $clog2(REV_STEPS + 1);
  localparam logic [STILL_W-1:0] REV_MAX = STILL_W'(REV_STEPS);
  localparam logic [POS_W-1:0]   POS_TOP = POS_W'(POS_MAX);

  shaft_state_t       state_q, state_d;
  logic [POS_W-1:0]   pos_q;
  logic               last_dir_q;
  logic [STILL_W-1:0] still_q;
  logic               fault_q;
  logic               moving_q;
  sensor_t            sensors_q, sensors_d;
  logic               tick;
  logic               at_limit;
  logic               reverse_ok;
`ifdef LIFT_DOOR_MODEL_EN
  logic [STILL_W-1:0] door_cnt_q;
  logic               door_open_q;
`endif

  // The timer runs in IDLE too: its ticks pace the still-timer. Every state
  // change restarts the period, which discards a partial step on abort.
  lift_step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_step_timer (
    .clock (clock),
    .reset (reset),
    .clear (state_d != state_q),
    .run   (state_q != CRASH),
    .tick  (tick)
  );

  assign sensors_d  = decode_sensors(pos_q, POS_MAX, SENSOR_W);
  assign at_limit   = (last_dir_q == DIR_UP) ? (pos_q == POS_TOP) : (pos_q == '0);
  assign reverse_ok = (direction == last_dir_q) || (still_q >= REV_MAX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = reverse_ok ? MOVE : CRASH;
`ifdef LIFT_DOOR_MODEL_EN
          if (door_open_q) state_d = CRASH;
`endif
        end
      end
      MOVE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (direction != last_dir_q) begin
          state_d = CRASH;
        end else if (tick && at_limit) begin
          state_d = CRASH;
        end
      end
      CRASH:   state_d = CRASH;
      default: state_d = CRASH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      last_dir_q <= DIR_UP;
      still_q    <= REV_MAX;
      fault_q    <= 1'b0;
      moving_q   <= 1'b0;
      sensors_q  <= '{top: 1'b0, middle_plus: 1'b0, middle_minus: 1'b0, bottom: 1'b1};
    end else begin
      state_q   <= state_d;
      moving_q  <= (state_d == MOVE);
      fault_q   <= fault_q | (state_d == CRASH);
      sensors_q <= sensors_d;

      // A completed step only moves the cabin if the plant stays in MOVE.
      if (state_q == MOVE && state_d == MOVE && tick) begin
        pos_q <= (last_dir_q == DIR_UP) ? pos_q + 1'b1 : pos_q - 1'b1;
      end

      if (state_q == IDLE && state_d == MOVE) begin
        last_dir_q <= direction;
      end

      if (state_q == MOVE && state_d == IDLE) begin
        still_q <= '0;
      end else if (state_q == IDLE && tick && still_q != REV_MAX) begin
        still_q <= still_q + 1'b1;
      end
    end
  end

`ifdef LIFT_DOOR_MODEL_EN
  // Position is frozen in IDLE, so the floor-window test is stable while
  // the door counter accumulates parked step periods.
  always_ff @(posedge clock) begin
    if (reset) begin
      door_cnt_q  <= '0;
      door_open_q <= 1'b0;
    end else if (state_q != IDLE || enable ||
                 !(sensors_d.top || sensors_d.middle_plus ||
                   sensors_d.middle_minus || sensors_d.bottom)) begin
      door_cnt_q  <= '0;
      door_open_q <= 1'b0;
    end else begin
      if (tick && door_cnt_q != REV_MAX) door_cnt_q <= door_cnt_q + 1'b1;
      door_open_q <= (door_cnt_q == REV_MAX);
    end
  end

  assign door_open = door_open_q;
`endif

  assign top          = sensors_q.top;
  assign middle_plus  = sensors_q.middle_plus;
  assign middle_minus = sensors_q.middle_minus;
  assign bottom       = sensors_q.bottom;
  assign position     = pos_q;
  assign moving       = moving_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_lift_shaft_model.sv
// Directed bench for lift_shaft_model with POS_MAX=20, STEP_DIV=4,
// SENSOR_W=1, REV_STEPS=2 (MID=10). Inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_lift_shaft_model;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       direction;
  logic       top, middle_plus, middle_minus, bottom;
  logic [7:0] position;
  logic       moving;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;

  lift_shaft_model #(
    .POS_MAX   (20),
    .STEP_DIV  (4),
    .SENSOR_W  (1),
    .REV_STEPS (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .direction    (direction),
    .top          (top),
    .middle_plus  (middle_plus),
    .middle_minus (middle_minus),
    .bottom       (bottom),
    .position     (position),
    .moving       (moving),
    .fault        (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Leaves reset asserted after two edges; the caller checks, then releases.
  task automatic hold_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    direction = 1'b1;
    step(2);
  endtask

  task automatic release_reset(input logic en, input logic dir);
    reset     = 1'b0;
    enable    = en;
    direction = dir;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:1] exp_bottom;
    logic [10:1] exp_mid_minus;
    // Sensors seen one edge into step k reflect position k-1.
    exp_bottom    = 10'b00_0000_0011;
    exp_mid_minus = 10'b10_0000_0000;

    // Reset state
    hold_reset();
    check("rst_position", position, 0);
    check("rst_bottom", bottom, 1);
    check("rst_top", top, 0);
    check("rst_mid_plus", middle_plus, 0);
    check("rst_mid_minus", middle_minus, 0);
    check("rst_fault", fault, 0);
    check("rst_moving", moving, 0);

    // Climb: entry edge, then one position unit every 4 cycles
    release_reset(1'b1, 1'b1);
    step(1);
    check("climb_moving", moving, 1);
    check("climb_pos_start", position, 0);
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check($sformatf("climb_bottom_%0d", k), bottom, exp_bottom[k]);
      check($sformatf("climb_mid_minus_%0d", k), middle_minus, exp_mid_minus[k]);
      step(3);
      check($sformatf("climb_pos_%0d", k), position, k);
    end
    step(1);
    check("mid_both_plus", middle_plus, 1);
    check("mid_both_minus", middle_minus, 1);
    check("mid_bottom", bottom, 0);
    check("mid_top", top, 0);

    // Overrun: 20 reached 39 cycles later, crash on the following tick
    step(39);
    check("ovr_pos_top", position, 20);
    check("ovr_top_sensor", top, 1);
    check("ovr_moving_before", moving, 1);
    step(3);
    check("ovr_fault_before", fault, 0);
    step(1);
    check("ovr_fault", fault, 1);
    check("ovr_moving", moving, 0);
    check("ovr_pos_frozen", position, 20);
    step(10);
    check("ovr_fault_held", fault, 1);
    check("ovr_pos_held", position, 20);
    enable = 1'b0;
    step(5);
    check("ovr_fault_enable_low", fault, 1);

    // Reversal after 1 step period standstill -> crash
    hold_reset();
    check("rev1_reset_fault", fault, 0);
    check("rev1_reset_pos", position, 0);
    release_reset(1'b1, 1'b1);
    step(21);
    check("rev1_pos5", position, 5);
    enable = 1'b0;
    step(5);
    check("rev1_idle", moving, 0);
    enable    = 1'b1;
    direction = 1'b0;
    step(1);
    check("rev1_fault", fault, 1);
    check("rev1_moving", moving, 0);
    check("rev1_pos", position, 5);

    // Reversal after 2 step periods standstill -> legal
    hold_reset();
    release_reset(1'b1, 1'b1);
    step(21);
    check("rev2_pos5", position, 5);
    enable = 1'b0;
    step(9);
    enable    = 1'b1;
    direction = 1'b0;
    step(1);
    check("rev2_moving", moving, 1);
    check("rev2_fault", fault, 0);
    step(4);
    check("rev2_pos4", position, 4);
    check("rev2_fault_after", fault, 0);

    // Abort mid-step: drop enable 2 cycles into the step
    step(2);
    enable = 1'b0;
    step(1);
    check("abort_pos", position, 4);
    check("abort_moving", moving, 0);
    enable = 1'b1;
    step(4);
    check("abort_no_early_step", position, 4);
    step(1);
    check("abort_full_step", position, 3);
    check("abort_fault", fault, 0);

    // Instant direction flip while moving -> crash
    hold_reset();
    release_reset(1'b1, 1'b1);
    step(3);
    direction = 1'b0;
    step(1);
    check("flip_fault", fault, 1);
    check("flip_pos", position, 0);

    // Step down at the bottom -> crash (reversal allowed straight out of reset)
    hold_reset();
    release_reset(1'b1, 1'b0);
    step(4);
    check("floor_moving", moving, 1);
    check("floor_fault_before", fault, 0);
    step(1);
    check("floor_fault", fault, 1);
    check("floor_pos", position, 0);
    check("floor_moving_after", moving, 0);

    // Reset mid-move at position 7
    hold_reset();
    release_reset(1'b1, 1'b1);
    step(29);
    check("rmid_pos7", position, 7);
    step(2);
    reset = 1'b1;
    step(1);
    check("rmid_pos", position, 0);
    check("rmid_moving", moving, 0);
    check("rmid_fault", fault, 0);
    check("rmid_bottom", bottom, 1);
    release_reset(1'b0, 1'b1);
    step(3);
    check("rmid_idle_pos", position, 0);
    check("rmid_idle_moving", moving, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
